// File: rtl/serial_addsub_pkg.sv
// Shared types and encodings for the bit-serial add/subtract engine.
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   localparam logic ADD = 1'b1;
   localparam logic SUB = 1'b0;

endpackage

// File: rtl/serial_addsub_fas_bit.sv
// Combinational 1-bit full adder cell; the sequencer feeds it one bit pair per clock.
module fas_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract engine: LSB-first through a single full-adder cell.
// Optional signed-overflow flag enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             a_ns,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow
);

   localparam int                CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   state_t             r_state;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_res;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_ans;
   logic               r_carry;

   logic w_b;
   logic w_s;
   logic w_cout;

   // Subtract is A + ~B + 1: invert B here, the +1 comes from the preset carry.
   assign w_b = (r_ans == ADD) ? r_b[0] : ~r_b[0];

   fas_bit u_cell (
      .a    (r_a[0]),
      .b    (w_b),
      .cin  (r_carry),
      .s    (w_s),
      .cout (w_cout)
   );

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values; reset is synchronous, hence only clk in the sensitivity list.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_cnt   <= '0;
         r_ans   <= ADD;
         r_carry <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a     <= op_a;
                  r_b     <= op_b;
                  r_ans   <= a_ns;
                  r_carry <= (a_ns == SUB);
                  r_cnt   <= '0;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               r_carry <= w_cout;
               r_res   <= {w_s, r_res[WIDTH-1:1]};
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               if (r_cnt == LAST) begin
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign result    = r_res;
   assign cout      = r_carry;

`ifdef SERIAL_ADDSUB_OVF_EN
   logic r_cin_msb;

   // Carry into the MSB is the cell's carry-in on the last step.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cin_msb <= 1'b0;
      end else if (r_state == SHIFT && r_cnt == LAST) begin
         r_cin_msb <= r_carry;
      end
   end

   assign overflow = r_cin_msb ^ r_carry;
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub (WIDTH=8): driver pushes expectations,
// a negedge monitor pops and compares on every output handshake.
module tb_serial_addsub;
   import serial_addsub_pkg::*;

   localparam int W = 8;
`ifdef SERIAL_ADDSUB_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   typedef struct packed {
      logic [W-1:0] res;
      logic         c;
      logic         v;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         a_ns;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         cout;
   logic         overflow;

   serial_addsub #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .a_ns      (a_ns),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t exp_q[$];
   int   acc_q[$];
   logic prev_ov = 1'b0;
   exp_t mon_e;
   int   mon_a;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ns);
      exp_t e;
      int   ua = int'(a);
      int   ub = int'(b);
      int   sa = int'($signed(a));
      int   sb = int'($signed(b));
      int   s;
      if (ns == ADD) begin
         e.res = W'(ua + ub);
         e.c   = (ua + ub) > 255;
         s     = sa + sb;
      end else begin
         e.res = W'(ua - ub);
         e.c   = (ua >= ub);
         s     = sa - sb;
      end
      e.v = OVF_EN && (s > 127 || s < -128);
      return e;
   endfunction

   // Monitor: latency on every out_valid rise, payload on every handshake.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         acc_q.delete();
         prev_ov = 1'b0;
      end else begin
         if (out_valid && !prev_ov) begin
            if (acc_q.size() == 0) begin
               check("latency_no_accept", 1, 0);
            end else begin
               mon_a = acc_q.pop_front();
               check("latency", cyc - mon_a, W);
            end
         end
         prev_ov = out_valid;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", 1, 0);
            end else begin
               mon_e = exp_q.pop_front();
               check("result", result, mon_e.res);
               check("cout", cout, mon_e.c);
               check("overflow", overflow, mon_e.v);
            end
         end
      end
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ns,
                        input exp_t e, output int acc);
      op_a     = a;
      op_b     = b;
      a_ns     = ns;
      in_valid = 1'b1;
      acc      = -1;
      for (int k = 0; k < 100 && acc < 0; k++) begin
         @(negedge clk);
         if (in_ready) begin
            acc = cyc + 1;
            exp_q.push_back(e);
            acc_q.push_back(acc);
         end
         @(posedge clk);
         #1;
      end
      if (acc < 0) check("accept_timeout", 0, 1);
   endtask

   task automatic drain();
      for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
         @(posedge clk);
         #1;
      end
      check("drain", exp_q.size(), 0);
   endtask

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         ns;
      exp_t         e;
   } vec_t;

   vec_t vecs[5];
   int   acc;
   int   prev_acc;
   exp_t bp_e;

   initial begin
      vecs[0] = '{a: 8'h0F, b: 8'h01, ns: ADD, e: '{res: 8'h10, c: 1'b0, v: 1'b0}};
      vecs[1] = '{a: 8'hFF, b: 8'h01, ns: ADD, e: '{res: 8'h00, c: 1'b1, v: 1'b0}};
      vecs[2] = '{a: 8'h7F, b: 8'h01, ns: ADD, e: '{res: 8'h80, c: 1'b0, v: OVF_EN}};
      vecs[3] = '{a: 8'h05, b: 8'h07, ns: SUB, e: '{res: 8'hFE, c: 1'b0, v: 1'b0}};
      vecs[4] = '{a: 8'h80, b: 8'h01, ns: SUB, e: '{res: 8'h7F, c: 1'b1, v: OVF_EN}};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op_a      = '0;
      op_b      = '0;
      a_ns      = ADD;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_cout", cout, 0);
      check("rst_overflow", overflow, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed add/subtract vectors, one at a time.
      foreach (vecs[i]) begin
         issue(vecs[i].a, vecs[i].b, vecs[i].ns, vecs[i].e, acc);
         in_valid = 1'b0;
         drain();
      end

      // Backpressure: A5-5A = 4B, no borrow, signed overflow.
      bp_e      = '{res: 8'h4B, c: 1'b1, v: OVF_EN};
      out_ready = 1'b0;
      issue(8'hA5, 8'h5A, SUB, bp_e, acc);
      in_valid = 1'b0;
      for (int k = 0; k < 50 && !out_valid; k++) begin
         @(posedge clk);
         #1;
      end
      check("bp_valid", out_valid, 1);
      for (int k = 0; k < 5; k++) begin
         check("bp_result", result, bp_e.res);
         check("bp_cout", cout, bp_e.c);
         check("bp_overflow", overflow, bp_e.v);
         check("bp_in_ready", in_ready, 0);
         in_valid = ~in_valid;
         op_a     = 8'hFF;
         op_b     = 8'hFF;
         a_ns     = ADD;
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_idle_in_ready", in_ready, 1);
      check("bp_idle_out_valid", out_valid, 0);

      // Reset during the third SHIFT cycle aborts the operation.
      issue(8'hAA, 8'h11, ADD, model(8'hAA, 8'h11, ADD), acc);
      in_valid = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_in_ready", in_ready, 1);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_result", result, 0);
      rst_n = 1'b1;
      issue(8'h12, 8'h34, ADD, '{res: 8'h46, c: 1'b0, v: 1'b0}, acc);
      in_valid = 1'b0;
      drain();

      // Back-to-back with in_valid held high.
      prev_acc = 0;
      for (int i = 0; i < 20; i++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         logic         rn;
         ra = W'($urandom_range(0, 255));
         rb = W'($urandom_range(0, 255));
         rn = 1'($urandom_range(0, 1));
         issue(ra, rb, rn, model(ra, rb, rn), acc);
         if (i > 0) check("issue_interval", acc - prev_acc, W + 2);
         prev_acc = acc;
      end
      in_valid = 1'b0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
